// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer that shares one combinational ALU between two requesters.
// Operands are registered onto the ALU and the tagged result is returned on one response channel.
//
// state | meaning
// IDLE  | arbitrate and accept one request
// EXEC  | ALU inputs stable, capture alu_s at the end of the cycle
// RESP  | hold tagged result until rsp_ready
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last;
  logic             grant;
  logic             accept;
  logic             sel_legal;
  logic [WIDTH-1:0] grant_a, grant_b;
  logic [3:0]       grant_sel;

  // On a tie, serve the requester that was not served last.
  always_comb begin
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

  assign grant_a   = grant ? req1_a   : req0_a;
  assign grant_b   = grant ? req1_b   : req0_b;
  assign grant_sel = grant ? req1_sel : req0_sel;
  assign sel_legal = ({1'b0, grant_sel} < 5'(NUM_OPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nxt        = sel_legal ? EXEC : RESP;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      rsp_id  <= 1'b0;
      rsp_s   <= '0;
      rsp_err <= 1'b0;
      last    <= 1'b1;
    end else begin
      if (accept) begin
        alu_a   <= grant_a;
        alu_b   <= grant_b;
        alu_sel <= grant_sel;
        rsp_id  <= grant;
        last    <= grant;
        // Illegal selects skip the ALU and report immediately.
        if (!sel_legal) begin
          rsp_s   <= '0;
          rsp_err <= 1'b1;
        end
      end
      if (state == EXEC) begin
        rsp_s   <= alu_s;
        rsp_err <= 1'b0;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
